data_unpack: RTL and testbench
==============================

Name: data_unpack

Overview:
- Width gearbox. Converts a packetised stream of 32-bit words into a continuous stream of 7-bit symbols, preserving packet framing (sop/eop).
- Input bits form one continuous bitstream: LSB-first within each word, words in arrival order.
- Sits between a 32-bit packet source (ready/valid backpressure) and a 7-bit symbol consumer that is always ready.

Parameters:
- IN_W, 32, input word width.
- SYM_W, 7, output symbol width.
- BUF_W, IN_W+SYM_W-1 (38), bit-buffer width; derived, not for override.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- data_in  in  IN_W  input word; bit 0 is the first bit in time.
- valid_in  in  1  data_in/sop_in/eop_in qualify.
- sop_in  in  1  word is the first of a packet.
- eop_in  in  1  word is the last of a packet.
- ready_out  out  1  block can accept a word this cycle.
- valid_out  out  1  data_out holds a symbol this cycle.
- sop_out  out  1  symbol is the first of a packet.
- eop_out  out  1  symbol is the last of a packet.
- data_out  out  SYM_W  symbol; bit 0 is the earliest bit.

Behaviour:
- State:
  - bit buffer buf[BUF_W-1:0] with fill count cnt (0..38).
  - flag sop_pend: next emitted symbol carries sop.
  - flag eop_pend: packet end has been accepted, flush in progress.
- ready_out is combinational: (cnt < SYM_W) && !eop_pend. It is 1 immediately out of reset.
- Accept:
  - Occurs on an edge where valid_in && ready_out.
  - The word is appended at buf[cnt +: 32]; cnt += 32.
  - If sop_in: set sop_pend, and discard any residual bits first (cnt reset to 0 before append).
  - If eop_in: set eop_pend.
  - valid_in=0 words are ignored. No emission happens on an accept edge, since cnt < 7 there.
- Emit:
  - Occurs on an edge where cnt >= SYM_W.
  - Register data_out = buf[6:0], valid_out=1, sop_out=sop_pend.
  - Shift buf right by 7; cnt -= 7; clear sop_pend.
  - eop_out=1 iff eop_pend && the new cnt == 0; this also clears eop_pend.
- Flush: on an edge where eop_pend && 0 < cnt < 7:
  - Emit the residual bits in data_out[cnt-1:0], upper bits zero-padded.
  - Assert eop_out (plus sop_out if sop_pend); cnt=0; clear eop_pend.
- Otherwise valid_out, sop_out, eop_out = 0. data_out holds its last value; don't-care when valid_out=0.
- Latency: the first symbol of an accepted word is registered on the edge after acceptance.
- Sustained rate: one symbol per cycle. ready_out reasserts the cycle after cnt drops below 7.
- Per word: 4 or 5 symbols depending on residual. A packet of N words yields ceil(32N/7) symbols.
- Word with both sop_in and eop_in is a single-word packet and is legal.
- Reset (async, any time, including mid-packet): all outputs 0, cnt=0, sop_pend=eop_pend=0, buffer contents discarded.
- No output backpressure. The consumer must take every symbol where valid_out=1.

Decomposition:
- Package data_unpack_pkg:
  - IN_W, SYM_W, BUF_W constants.
  - typedef sym_t (logic [SYM_W-1:0]).
  - typedef cnt_t (6-bit count).
- Single module; the bit buffer plus count is kept inline, no sub-module.

Test Plan:
- Single word, sop+eop, data 0xFFFFFFFF:
  - 5 symbols {sop,eop,data}: 1_0_1111111, 0_0_1111111, 0_0_1111111, 0_0_1111111, 0_1_0001111.
  - ready_out low for the 5 emit cycles.
- Two-word packet, sop on 0x00000001, eop on 0x80000000:
  - 10 symbols: first 1_0_0000001; symbols 2-8 are 0.
  - symbol 9 is 0000000 (bits 56..62, bit 63 not yet reached).
  - symbol 10 is 0_1_0000001 (bit 63 padded).
- Five-word packet of 0xAAAAAAAA with valid_in dropped between words:
  - exactly 23 symbols, only after valid words.
  - sop on the first symbol only, eop on the 23rd only.
  - bit pattern continuous across word boundaries.
- Back-to-back packets (eop word immediately followed by a sop word held valid):
  - second packet not accepted until the flush symbol of the first is out.
  - second packet's first symbol has sop_out=1 and no stale residual bits.
- Async reset asserted mid-packet with cnt>0:
  - valid_out drops with no clock edge.
  - after release ready_out=1, and a new sop+eop word of 0x0000007F yields 1_0_1111111, then 0_0_0000000 three times, then 0_1_0000000.
- valid_in=1 while ready_out=0:
  - word not consumed; source holds it.
  - the word is accepted on the first edge where ready_out=1, with correct framing.

Source files
------------

// File: rtl/data_unpack_pkg.sv
// Shared widths and types for the 32-to-7 bit gearbox.
// Imported by data_unpack; holds no logic.
package data_unpack_pkg;

  localparam int IN_W  = 32;
  localparam int SYM_W = 7;
  localparam int BUF_W = IN_W + SYM_W - 1;

  typedef logic [SYM_W-1:0] sym_t;
  typedef logic [5:0]       cnt_t;

endpackage

// File: rtl/data_unpack.sv
// Width gearbox: 32-bit packet words in, 7-bit symbols out, LSB-first,
// with sop/eop framing kept and a zero-padded flush symbol at packet end.
// Ports: clk, rst (async, active-high); data_in/valid_in/sop_in/eop_in and
// ready_out on the word side; valid_out/sop_out/eop_out/data_out symbols.
module data_unpack
  import data_unpack_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [IN_W-1:0] data_in,
  input  logic            valid_in,
  input  logic            sop_in,
  input  logic            eop_in,
  output logic            ready_out,
  output logic            valid_out,
  output logic            sop_out,
  output logic            eop_out,
  output sym_t            data_out
);

  localparam cnt_t C_SYM = cnt_t'(SYM_W);
  localparam cnt_t C_IN  = cnt_t'(IN_W);

  // Bits at and above r_cnt are always zero, so appends can OR and the
  // flush symbol comes out already zero-padded.
  logic [BUF_W-1:0] r_buf;
  logic [BUF_W-1:0] w_buf_nxt;
  logic [BUF_W-1:0] w_word_ext;
  cnt_t             r_cnt;
  cnt_t             w_cnt_nxt;
  cnt_t             w_base;
  logic             r_sop_pend;
  logic             r_eop_pend;
  logic             w_sop_pend_nxt;
  logic             w_eop_pend_nxt;
  logic             w_accept;
  logic             w_emit;
  logic             w_flush;
  logic             w_vld_nxt;
  logic             w_sop_nxt;
  logic             w_eop_nxt;
  sym_t             w_data_nxt;

  assign ready_out  = (r_cnt < C_SYM) && !r_eop_pend;
  assign w_accept   = valid_in && ready_out;
  assign w_emit     = r_cnt >= C_SYM;
  assign w_flush    = r_eop_pend && (r_cnt != '0) && (r_cnt < C_SYM);

  // sop drops any residual bits from an unterminated previous packet.
  assign w_base     = sop_in ? '0 : r_cnt;
  assign w_word_ext = BUF_W'(data_in) << w_base;

  always_comb begin
    w_buf_nxt      = r_buf;
    w_cnt_nxt      = r_cnt;
    w_sop_pend_nxt = r_sop_pend;
    w_eop_pend_nxt = r_eop_pend;
    w_vld_nxt      = 1'b0;
    w_sop_nxt      = 1'b0;
    w_eop_nxt      = 1'b0;
    w_data_nxt     = data_out;
    if (w_accept) begin
      w_buf_nxt      = (sop_in ? '0 : r_buf) | w_word_ext;
      w_cnt_nxt      = w_base + C_IN;
      w_sop_pend_nxt = r_sop_pend | sop_in;
      w_eop_pend_nxt = eop_in;
    end else if (w_emit) begin
      w_buf_nxt      = r_buf >> SYM_W;
      w_cnt_nxt      = r_cnt - C_SYM;
      w_vld_nxt      = 1'b1;
      w_sop_nxt      = r_sop_pend;
      w_data_nxt     = r_buf[SYM_W-1:0];
      w_sop_pend_nxt = 1'b0;
      // Exact multiple of 7: the last full symbol closes the packet.
      if (r_eop_pend && (r_cnt == C_SYM)) begin
        w_eop_nxt      = 1'b1;
        w_eop_pend_nxt = 1'b0;
      end
    end else if (w_flush) begin
      w_buf_nxt      = '0;
      w_cnt_nxt      = '0;
      w_vld_nxt      = 1'b1;
      w_sop_nxt      = r_sop_pend;
      w_eop_nxt      = 1'b1;
      w_data_nxt     = r_buf[SYM_W-1:0];
      w_sop_pend_nxt = 1'b0;
      w_eop_pend_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf      <= '0;
      r_cnt      <= '0;
      r_sop_pend <= 1'b0;
      r_eop_pend <= 1'b0;
      valid_out  <= 1'b0;
      sop_out    <= 1'b0;
      eop_out    <= 1'b0;
      data_out   <= '0;
    end else begin
      r_buf      <= w_buf_nxt;
      r_cnt      <= w_cnt_nxt;
      r_sop_pend <= w_sop_pend_nxt;
      r_eop_pend <= w_eop_pend_nxt;
      valid_out  <= w_vld_nxt;
      sop_out    <= w_sop_nxt;
      eop_out    <= w_eop_nxt;
      data_out   <= w_data_nxt;
    end
  end

endmodule

// File: tb/tb_data_unpack.sv
// Bench for data_unpack: packet-level scoreboard of {sop,eop,data}
// symbols plus handshake, latency and async-reset checks.
module tb_data_unpack;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] data_in = '0;
  logic        valid_in = 1'b0;
  logic        sop_in = 1'b0;
  logic        eop_in = 1'b0;
  logic        ready_out;
  logic        valid_out;
  logic        sop_out;
  logic        eop_out;
  logic [6:0]  data_out;

  int n_chk = 0;
  int n_err = 0;

  logic [8:0]  exp_q[$];
  logic [31:0] pkt[$];
  int          waits_q[$];
  time         t_acc;
  time         t_first_acc;
  time         t_eop = 0;

  data_unpack dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .valid_in (valid_in),
    .sop_in   (sop_in),
    .eop_in   (eop_in),
    .ready_out(ready_out),
    .valid_out(valid_out),
    .sop_out  (sop_out),
    .eop_out  (eop_out),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected symbols from the packet's concatenated LSB-first bitstream.
  task automatic push_pkt();
    int tot;
    int nsym;
    int idx;
    logic [31:0] w;
    logic [8:0]  e;
    tot  = 32 * pkt.size();
    nsym = (tot + 6) / 7;
    for (int s = 0; s < nsym; s++) begin
      e = '0;
      for (int b = 0; b < 7; b++) begin
        idx = s * 7 + b;
        if (idx < tot) begin
          w = pkt[idx / 32];
          e[b] = w[idx % 32];
        end
      end
      e[8] = (s == 0);
      e[7] = (s == nsym - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic send_word(input logic [31:0] d, input logic s,
                           input logic e, output int waits);
    waits = 0;
    @(negedge clk);
    data_in  = d;
    sop_in   = s;
    eop_in   = e;
    valid_in = 1'b1;
    while (!ready_out && waits < 200) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 200) chk("accept_timeout", 32'd1, 32'd0);
    @(posedge clk);
    t_acc = $time;
    #1;
    valid_in = 1'b0;
    sop_in   = 1'b0;
    eop_in   = 1'b0;
    data_in  = $urandom;
  endtask

  task automatic send_pkt(input int gap);
    int wt;
    waits_q.delete();
    push_pkt();
    for (int i = 0; i < pkt.size(); i++) begin
      send_word(pkt[i], i == 0, i == pkt.size() - 1, wt);
      waits_q.push_back(wt);
      if (i == 0) t_first_acc = t_acc;
      repeat (gap) @(posedge clk);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain", exp_q.size(), 0);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    logic [8:0] e;
    if (!rst && valid_out) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_sym", {sop_out, eop_out, data_out}, 32'h1ff);
      end else begin
        e = exp_q.pop_front();
        chk("sym", {sop_out, eop_out, data_out}, e);
      end
      if (eop_out) t_eop = $time;
    end
    if (!rst && !valid_out && (sop_out || eop_out))
      chk("idle_flags", {sop_out, eop_out}, 0);
  end

  initial begin
    int wt;
    #12;
    chk("rst_valid", valid_out, 0);
    chk("rst_ready", ready_out, 1);
    @(negedge clk);
    rst = 1'b0;

    // Single word sop+eop, all ones; ready held low across 5 emit cycles.
    pkt = {};
    pkt.push_back(32'hFFFFFFFF);
    push_pkt();
    send_word(32'hFFFFFFFF, 1'b1, 1'b1, wt);
    @(negedge clk);
    chk("latency_valid", valid_out, 0);
    chk("busy_ready0", ready_out, 0);
    for (int k = 1; k < 5; k++) begin
      @(negedge clk);
      chk("busy_ready", ready_out, 0);
    end
    @(negedge clk);
    chk("ready_back", ready_out, 1);
    drain();

    // Two words with a single bit at each end of the stream.
    pkt = {};
    pkt.push_back(32'h00000001);
    pkt.push_back(32'h80000000);
    send_pkt(0);
    drain();

    // Five words with valid dropped between them.
    pkt = {};
    repeat (5) pkt.push_back(32'hAAAAAAAA);
    send_pkt(3);
    drain();

    // Words offered while ready is low are held, then taken.
    pkt = {};
    pkt.push_back(32'h12345678);
    pkt.push_back(32'h9ABCDEF0);
    pkt.push_back(32'h0F0F0F0F);
    send_pkt(0);
    chk("held_w1", waits_q[1], 4);
    chk("held_w2", waits_q[2], 5);
    drain();

    // Back-to-back packets: second sop waits for the first flush.
    pkt = {};
    pkt.push_back(32'hDEADBEEF);
    pkt.push_back(32'hFFFFFFFF);
    send_pkt(0);
    pkt = {};
    pkt.push_back(32'h00000055);
    send_pkt(0);
    chk("b2b_after_flush", t_first_acc > t_eop, 1);
    drain();

    // Async reset mid-packet.
    pkt = {};
    pkt.push_back(32'h12345678);
    push_pkt();
    send_word(32'h12345678, 1'b1, 1'b0, wt);
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_valid", valid_out, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_valid", valid_out, 0);
    chk("async_ready", ready_out, 1);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", ready_out, 1);
    pkt = {};
    pkt.push_back(32'h0000007F);
    send_pkt(0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1);
  end

endmodule
